// File: rtl/led_test_pkg.sv
// rtl/led_test_pkg.sv - shared state encoding and counter-width helper for led_test
package led_test_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COUNT    = 2'b01,
    WAIT_REL = 2'b10
  } state_t;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// rtl/edge_detect_rise.sv - registered rising-edge detector for the SP level input
module edge_detect_rise (
  input  logic CLK,
  input  logic RSTn,
  input  logic SP,
  output logic sp_rise
);

  logic sp_q;

  always_ff @(posedge CLK) begin
    if (RSTn) begin
      sp_q <= 1'b0;
    end else begin
      sp_q <= SP;
    end
  end

  // Clearing sp_q on reset makes an SP level held through reset look like a fresh edge.
  assign sp_rise = SP & ~sp_q;

endmodule

// File: rtl/led_test.sv
// rtl/led_test.sv - one-shot STEP pulse generator; optional STEP_RETRIGGER_EN extends an active pulse
module led_test
  import led_test_pkg::*;
#(
  parameter int NUM_COUNT = 25000000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic SP,
  output logic STEP
);

  localparam int CNT_W = cnt_width(NUM_COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_COUNT - 1);

  state_t           State;
  logic [CNT_W-1:0] count_r;
  logic             sp_rise;

  edge_detect_rise u_edge (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .SP      (SP),
    .sp_rise (sp_rise)
  );

  always_ff @(posedge CLK) begin
    if (RSTn) begin
      State   <= IDLE;
      count_r <= '0;
      STEP    <= 1'b0;
    end else begin
      case (State)
        IDLE: begin
          if (sp_rise) begin
            State   <= COUNT;
            count_r <= '0;
            STEP    <= 1'b1;
          end
        end
        COUNT: begin
`ifdef STEP_RETRIGGER_EN
          if (sp_rise) begin
            count_r <= '0;
            STEP    <= 1'b1;
          end else
`endif
          if (count_r == LAST) begin
            State   <= WAIT_REL;
            count_r <= '0;
            STEP    <= 1'b0;
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        WAIT_REL: begin
          // Re-arm only once the button has been let go.
          if (!SP) begin
            State <= IDLE;
          end
        end
        default: begin
          State   <= IDLE;
          count_r <= '0;
          STEP    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_test.sv
// tb/tb_led_test.sv - self-checking bench for led_test at NUM_COUNT=5 and NUM_COUNT=1
module tb_led_test;

`ifdef STEP_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic CLK  = 1'b0;
  logic RSTn = 1'b1;
  logic SP   = 1'b0;
  logic step5;
  logic step1;

  led_test #(.NUM_COUNT(5)) dut5 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .SP   (SP),
    .STEP (step5)
  );

  led_test #(.NUM_COUNT(1)) dut1 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .SP   (SP),
    .STEP (step1)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // Reference model: a pulse is described by the edge index it started on.
  int nc [2] = '{5, 1};
  int m_start [2];
  bit m_pulse [2];
  bit m_wait  [2];
  bit m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%0d expected=%0d", tag, t, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s);
    bit rise;
    rise = s && !m_prev;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_pulse[i] = 1'b0;
        m_wait[i]  = 1'b0;
      end else if (m_pulse[i]) begin
        if (RETRIG && rise) begin
          m_start[i] = t;
        end else if (t - m_start[i] == nc[i]) begin
          m_pulse[i] = 1'b0;
          m_wait[i]  = 1'b1;
        end
      end else if (m_wait[i]) begin
        if (!s) m_wait[i] = 1'b0;
      end else if (rise) begin
        m_pulse[i] = 1'b1;
        m_start[i] = t;
      end
    end
    m_prev = r ? 1'b0 : s;
  endtask

  function automatic int exp_state(input int i);
    return m_pulse[i] ? 1 : (m_wait[i] ? 2 : 0);
  endfunction

  function automatic int exp_cnt(input int i);
    return m_pulse[i] ? (t - m_start[i]) : 0;
  endfunction

  task automatic cyc(input bit r, input bit s, input string tag);
    @(negedge CLK);
    RSTn = r;
    SP   = s;
    @(posedge CLK);
    #1;
    t++;
    model_edge(r, s);
    check({tag, "/step5"},  step5,         32'(m_pulse[0]));
    check({tag, "/state5"}, dut5.State,    32'(exp_state(0)));
    check({tag, "/cnt5"},   dut5.count_r,  32'(exp_cnt(0)));
    check({tag, "/step1"},  step1,         32'(m_pulse[1]));
    check({tag, "/state1"}, dut1.State,    32'(exp_state(1)));
    check({tag, "/cnt1"},   dut1.count_r,  32'(exp_cnt(1)));
  endtask

  initial begin
    bit s;
    m_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_start[i] = 0;
      m_pulse[i] = 1'b0;
      m_wait[i]  = 1'b0;
    end

    // Reset held for two cycles.
    cyc(1'b1, 1'b0, "reset");
    cyc(1'b1, 1'b0, "reset");

    // Single-cycle SP after reset.
    cyc(1'b0, 1'b1, "single");
    repeat (8) cyc(1'b0, 1'b0, "single");

    // SP held high: one pulse, wait for release.
    repeat (20) cyc(1'b0, 1'b1, "held");
    repeat (3) cyc(1'b0, 1'b0, "held");

    // Second SP edge three cycles into an active pulse.
    cyc(1'b0, 1'b1, "retrig");
    cyc(1'b0, 1'b0, "retrig");
    cyc(1'b0, 1'b0, "retrig");
    cyc(1'b0, 1'b1, "retrig");
    repeat (10) cyc(1'b0, 1'b0, "retrig");

    // Reset while count_r=2 with SP still high, then SP high at release.
    cyc(1'b0, 1'b1, "midreset");
    cyc(1'b0, 1'b0, "midreset");
    cyc(1'b0, 1'b0, "midreset");
    cyc(1'b1, 1'b1, "midreset");
    cyc(1'b1, 1'b1, "midreset");
    cyc(1'b0, 1'b1, "midreset");
    repeat (8) cyc(1'b0, 1'b0, "midreset");

    // Randomized SP activity with rare resets.
    s = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) s = ~s;
      cyc(($urandom_range(0, 63) == 0), s, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
